// File: rtl/adder_sweep_checker.sv
// Exhaustive self-test engine for a combinational adder. It steps every (A, B)
// operand pair, checks {cout, sum} against A+B, and records errors and the first failure.
module adder_sweep_checker #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [2*WIDTH:0] err_count,
  output logic             fail_valid,
  output logic [WIDTH-1:0] first_fail_a,
  output logic [WIDTH-1:0] first_fail_b
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0]   OP_ONE   = WIDTH'(1);
  localparam logic [2*WIDTH:0]   ERR_ONE  = (2*WIDTH+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2*WIDTH:0] err_q, err_d;
  logic             fv_q, fv_d;
  logic [WIDTH-1:0] ffa_q, ffa_d, ffb_q, ffb_d;

  logic [WIDTH:0]   expected;
  logic             mismatch;

  assign expected = {1'b0, a_q} + {1'b0, b_q};
  assign mismatch = ({dut_cout, dut_sum} != expected);

  // NOTE: every next-state signal takes its hold value first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    err_d   = err_q;
    fv_d    = fv_q;
    ffa_d   = ffa_q;
    ffb_d   = ffb_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_SETTLE;
          cnt_d   = CNT_LOAD;
          a_d     = '0;
          b_d     = '0;
          err_d   = '0;
          fv_d    = 1'b0;
          ffa_d   = '0;
          ffb_d   = '0;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          state_d = S_IDLE;
          a_d     = '0;
          b_d     = '0;
        end else if (cnt_q == '0) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_CHECK: begin
        // An aborted check is discarded entirely, including its mismatch.
        if (abort) begin
          state_d = S_IDLE;
          a_d     = '0;
          b_d     = '0;
        end else begin
          if (mismatch) begin
            err_d = err_q + ERR_ONE;
            if (!fv_q) begin
              fv_d  = 1'b1;
              ffa_d = a_q;
              ffb_d = b_q;
            end
          end
          if ((&a_q) && (&b_q)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SETTLE;
            cnt_d   = CNT_LOAD;
            b_d     = b_q + OP_ONE;
            if (&b_q) a_d = a_q + OP_ONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      ffa_q   <= '0;
      ffb_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      ffa_q   <= ffa_d;
      ffb_q   <= ffb_d;
    end
  end

  assign dut_a        = a_q;
  assign dut_b        = b_q;
  assign busy         = (state_q == S_SETTLE) || (state_q == S_CHECK);
  assign done         = (state_q == S_DONE);
  assign pass         = done && (err_q == '0);
  assign err_count    = err_q;
  assign fail_valid   = fv_q;
  assign first_fail_a = ffa_q;
  assign first_fail_b = ffb_q;

endmodule

// File: tb/tb_adder_sweep_checker.sv
// Bench for adder_sweep_checker (WIDTH=4, SETTLE=3) with a fault-injectable adder model.
// Expected sweep results are queued at start and compared when done rises.
module tb_adder_sweep_checker;

  localparam int W  = 4;
  localparam int ST = 3;
  localparam int SWEEP_CYC = (1 << (2*W)) * (ST + 1);

  logic         clk = 1'b0;
  logic         reset, start, abort;
  logic [W-1:0] dut_a, dut_b, adder_sum;
  logic         adder_cout;
  logic         busy, done, pass, fail_valid;
  logic [2*W:0] err_count;
  logic [W-1:0] first_fail_a, first_fail_b;

  int fault = 0;
  int cyc   = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2*W:0] err;
    logic         pass;
    logic         fv;
    logic [W-1:0] fa;
    logic [W-1:0] fb;
    int           done_cyc;
  } exp_t;

  exp_t sb_q[$];

  adder_sweep_checker #(.WIDTH(W), .SETTLE(ST)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .dut_a(dut_a), .dut_b(dut_b), .dut_sum(adder_sum), .dut_cout(adder_cout),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_valid(fail_valid), .first_fail_a(first_fail_a), .first_fail_b(first_fail_b)
  );

  // Adder under test: 0 ideal, 1 sum[0] stuck-at-0, 2 carry-out stuck-at-0.
  always_comb begin
    {adder_cout, adder_sum} = {1'b0, dut_a} + {1'b0, dut_b};
    if (fault == 1) adder_sum[0] = 1'b0;
    if (fault == 2) adder_cout = 1'b0;
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_start(output int start_edge);
    @(negedge clk);
    start = 1'b1;
    start_edge = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_exp(input int err, input logic p, input logic fv,
                          input int fa, input int fb, input int start_edge);
    exp_t e;
    e.err = (2*W+1)'(err);
    e.pass = p;
    e.fv = fv;
    e.fa = W'(fa);
    e.fb = W'(fb);
    e.done_cyc = start_edge + SWEEP_CYC;
    sb_q.push_back(e);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < SWEEP_CYC + 200) begin
      @(negedge clk);
      n++;
    end
    check(name, done, 1);
  endtask

  task automatic wait_a(input int val, input string name);
    int n = 0;
    while (dut_a !== W'(val) && n < SWEEP_CYC + 200) begin
      @(negedge clk);
      n++;
    end
    check(name, dut_a, val);
  endtask

  // Monitor: on each rising done, pop the expected sweep result and compare.
  initial begin
    logic prev_done = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1 && !prev_done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("sb_done_cycle", cyc, e.done_cyc);
          check("sb_err_count", err_count, e.err);
          check("sb_pass", pass, e.pass);
          check("sb_fail_valid", fail_valid, e.fv);
          check("sb_first_fail_a", first_fail_a, e.fa);
          check("sb_first_fail_b", first_fail_b, e.fb);
        end
      end
      prev_done = (done === 1'b1);
    end
  end

  initial begin
    int se;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    check("rst_fv", fail_valid, 0);
    check("rst_operands", {dut_a, dut_b, first_fail_a, first_fail_b}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Ideal adder: operand stepping, then hold in DONE.
    fault = 0;
    do_start(se);
    push_exp(0, 1'b1, 1'b0, 0, 0, se);
    check("busy_after_start", busy, 1);
    for (int k = 0; k <= 16; k++) begin
      check($sformatf("step_a_%0d", k), dut_a, k / 16);
      check($sformatf("step_b_%0d", k), dut_b, k % 16);
      repeat (ST + 1) @(negedge clk);
    end
    wait_done("done_ideal");
    repeat (3) @(negedge clk);
    check("hold_done", done, 1);
    check("hold_busy", busy, 0);
    check("hold_pass", pass, 1);
    check("hold_a", dut_a, 15);
    check("hold_b", dut_b, 15);

    // Sum[0] stuck-at-0, restarted from DONE: 128 odd sums, first at (0,1).
    fault = 1;
    do_start(se);
    push_exp(128, 1'b0, 1'b1, 0, 1, se);
    check("restart_done_clr", done, 0);
    check("restart_busy", busy, 1);
    wait_done("done_sum0");

    // Carry-out stuck-at-0, restarted from DONE: clears counters first.
    fault = 2;
    do_start(se);
    push_exp(120, 1'b0, 1'b1, 1, 15, se);
    check("restart_err_clr", err_count, 0);
    check("restart_fv_clr", fail_valid, 0);
    check("restart_operands", {dut_a, dut_b}, 0);
    wait_done("done_cout");

    // start while busy ignored; abort at a=10 keeps 45 carry errors for a=0..9.
    do_start(se);
    wait_a(5, "reach_a5");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_start_a", dut_a, 5);
    check("busy_start_b", dut_b, 0);
    check("busy_start_busy", busy, 1);
    wait_a(10, "reach_a10");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_operands", {dut_a, dut_b}, 0);
    check("abort_err", err_count, 45);
    check("abort_fv", fail_valid, 1);
    check("abort_ffa", first_fail_a, 1);
    check("abort_ffb", first_fail_b, 15);
    repeat (4) @(negedge clk);
    check("abort_stays_idle", {busy, done, dut_a, dut_b}, 0);

    // Reset mid-sweep with errors pending, then a clean sweep from (0,0).
    fault = 1;
    do_start(se);
    wait_a(3, "reach_a3");
    reset = 1'b1;
    @(negedge clk);
    check("midrst_flags", {busy, done, pass, fail_valid}, 0);
    check("midrst_err", err_count, 0);
    check("midrst_operands", {dut_a, dut_b, first_fail_a, first_fail_b}, 0);
    reset = 1'b0;
    fault = 0;
    do_start(se);
    push_exp(0, 1'b1, 1'b0, 0, 0, se);
    check("post_rst_operands", {dut_a, dut_b}, 0);
    wait_done("done_post_rst");

    repeat (2) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
